// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    // State encodings kept as plain constants so older code can keep using them.
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_RD_WAIT = 1'b1;

    typedef enum logic [0:0] {
        IDLE    = ST_IDLE,
        RD_WAIT = ST_RD_WAIT
    } state_t;

    // Port 0 is the core load/store port, port 1 the loader/debug master.
    typedef logic port_id_t;

    // Legal memory read latency window.
    localparam int MEM_LATENCY_MIN = 1;
    localparam int MEM_LATENCY_MAX = 4;

    // Read-wait counter width.
    localparam int CNT_W = 3;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: on a tie the port not granted last wins.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_id_t   last_grant,
    output logic [1:0] grant
);

    // One-hot grant; a lone requester always wins.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data memory between the core port (0) and the loader port (1).
// Writes complete in the accept cycle; a read holds the memory until its data
// returns, and only one read is ever in flight.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ready,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ready,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy
);

    generate
        if (MEM_LATENCY < MEM_LATENCY_MIN || MEM_LATENCY > MEM_LATENCY_MAX) begin : g_lat_check
            $error("dmem_arbiter: MEM_LATENCY %0d outside %0d..%0d",
                   MEM_LATENCY, MEM_LATENCY_MIN, MEM_LATENCY_MAX);
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY);

    // Ports gathered into arrays so the datapath can be indexed by port id.
    logic [1:0]        req_vec;
    logic [1:0]        we_vec;
    logic [ADDR_W-1:0] addr_arr  [2];
    logic [DATA_W-1:0] wdata_arr [2];

    assign req_vec      = {p1_req, p0_req};
    assign we_vec       = {p1_we, p0_we};
    assign addr_arr[0]  = p0_addr;
    assign addr_arr[1]  = p1_addr;
    assign wdata_arr[0] = p0_wdata;
    assign wdata_arr[1] = p1_wdata;

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    port_id_t          last_grant_reg;
    port_id_t          rd_port_reg;
    logic [ADDR_W-1:0] rd_addr_reg;
    logic              rvalid_reg [2];
    logic [DATA_W-1:0] rdata_reg  [2];

    logic [1:0] grant_raw;
    logic [1:0] grant_eff;
    port_id_t   sel_port;
    logic       accept;
    logic       accept_read;
    logic       rd_done;

    rr_arb2 u_rr_arb2 (
        .req        (req_vec),
        .last_grant (last_grant_reg),
        .grant      (grant_raw)
    );

    // Grants are only honoured while the memory is free.
    assign grant_eff   = (state_reg == IDLE) ? grant_raw : 2'b00;
    assign sel_port    = grant_raw[1];
    assign accept      = |grant_eff;
    assign accept_read = accept && !we_vec[sel_port];
    assign rd_done     = (state_reg == RD_WAIT) && (cnt_reg == CNT_W'(1));

    assign p0_ready = grant_eff[0];
    assign p1_ready = grant_eff[1];
    assign busy     = (state_reg == RD_WAIT);

    // Memory drive: granted port in IDLE, held read address in RD_WAIT, else zero.
    always_comb begin
        mem_wren    = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;
        if (state_reg == RD_WAIT) begin
            mem_addr = rd_addr_reg;
        end else if (accept) begin
            mem_wren    = we_vec[sel_port];
            mem_addr    = addr_arr[sel_port];
            mem_data_in = wdata_arr[sel_port];
        end
    end

    // Arbitration pointer and read-wait sequencing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            last_grant_reg <= 1'b1;
            rd_port_reg    <= 1'b0;
            rd_addr_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        last_grant_reg <= sel_port;
                    end
                    if (accept_read) begin
                        rd_addr_reg <= addr_arr[sel_port];
                        rd_port_reg <= sel_port;
                        cnt_reg     <= CNT_LOAD;
                        state_reg   <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (rd_done) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Per-port response: capture the returning word and pulse rvalid next cycle.
    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rvalid_reg[gi] <= 1'b0;
                rdata_reg[gi]  <= '0;
            end else begin
                rvalid_reg[gi] <= rd_done && (rd_port_reg == port_id_t'(gi));
                if (rd_done && (rd_port_reg == port_id_t'(gi))) begin
                    rdata_reg[gi] <= mem_data_out;
                end
            end
        end
    end

    assign p0_rvalid = rvalid_reg[0];
    assign p1_rvalid = rvalid_reg[1];
    assign p0_rdata  = rdata_reg[0];
    assign p1_rdata  = rdata_reg[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three instances at read latencies 1, 3 and 4, each
// with its own memory, checked every cycle against a transaction-level model.
module tb_dmem_arbiter;

    localparam int NI = 3;
    localparam int LAT [NI] = '{1, 3, 4};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        req0 [NI], we0 [NI], req1 [NI], we1 [NI];
    logic [31:0] addr0 [NI], wdata0 [NI], addr1 [NI], wdata1 [NI];
    logic        ready0 [NI], ready1 [NI], rvalid0 [NI], rvalid1 [NI];
    logic [31:0] rdata0 [NI], rdata1 [NI];
    logic        mem_wren [NI];
    logic [31:0] mem_addr [NI], mem_din [NI], mem_dout [NI];
    logic        busy [NI];

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT[gi])) u_dut (
            .clk          (clk),
            .reset        (rst_n),
            .p0_req       (req0[gi]),
            .p0_we        (we0[gi]),
            .p0_addr      (addr0[gi]),
            .p0_wdata     (wdata0[gi]),
            .p0_ready     (ready0[gi]),
            .p0_rvalid    (rvalid0[gi]),
            .p0_rdata     (rdata0[gi]),
            .p1_req       (req1[gi]),
            .p1_we        (we1[gi]),
            .p1_addr      (addr1[gi]),
            .p1_wdata     (wdata1[gi]),
            .p1_ready     (ready1[gi]),
            .p1_rvalid    (rvalid1[gi]),
            .p1_rdata     (rdata1[gi]),
            .mem_wren     (mem_wren[gi]),
            .mem_addr     (mem_addr[gi]),
            .mem_data_in  (mem_din[gi]),
            .mem_data_out (mem_dout[gi]),
            .busy         (busy[gi])
        );

        // Word memory; data_out reflects the address seen LAT cycles earlier.
        logic [31:0] mem   [64];
        logic [31:0] apipe [4];
        initial begin
            for (int k = 0; k < 64; k++) mem[k] <= 32'h0;
            mem[0] <= 32'h11;
            mem[1] <= 32'h22;
            mem[2] <= 32'h33;
            for (int k = 0; k < 4; k++) apipe[k] <= 32'h0;
        end
        always @(posedge clk) begin
            if (mem_wren[gi]) mem[mem_addr[gi][7:2]] <= mem_din[gi];
            apipe[0] <= mem_addr[gi];
            for (int k = 1; k < 4; k++) apipe[k] <= apipe[k-1];
        end
        assign mem_dout[gi] = mem[apipe[LAT[gi]-1][7:2]];
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s inst%0d t=%0t got %h want %h", name, inst, $time, act, exp);
        end
    endtask

    // Model: cycle index since reset, cycle the memory is free again, pending response.
    int          n_cyc [NI], free_at [NI], rv_due [NI];
    bit          last_m [NI], rv_port [NI];
    logic [31:0] rv_data [NI], rd_addr_m [NI], exp_rd0 [NI], exp_rd1 [NI];
    logic [31:0] mmem [NI][64];

    task automatic compare_all();
        bit          free;
        int          g;
        logic        gwe;
        logic [31:0] ga, gd, ea;
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                n_cyc[i] = 0; free_at[i] = 0; rv_due[i] = -1; last_m[i] = 1'b1;
                exp_rd0[i] = 32'h0; exp_rd1[i] = 32'h0;
                chk("rst_busy", i, 32'(busy[i]), 32'h0);
                chk("rst_rvalid0", i, 32'(rvalid0[i]), 32'h0);
                chk("rst_rvalid1", i, 32'(rvalid1[i]), 32'h0);
                chk("rst_rdata0", i, rdata0[i], 32'h0);
                chk("rst_rdata1", i, rdata1[i], 32'h0);
                chk("rst_wren", i, 32'(mem_wren[i]), 32'h0);
            end else begin
                free = (n_cyc[i] >= free_at[i]);
                if (rv_due[i] == n_cyc[i]) begin
                    if (rv_port[i]) exp_rd1[i] = rv_data[i];
                    else            exp_rd0[i] = rv_data[i];
                end
                g = -1;
                if (free) begin
                    if (req0[i] && req1[i]) g = last_m[i] ? 0 : 1;
                    else if (req0[i])       g = 0;
                    else if (req1[i])       g = 1;
                end
                gwe = (g == 1) ? we1[i]    : we0[i];
                ga  = (g == 1) ? addr1[i]  : addr0[i];
                gd  = (g == 1) ? wdata1[i] : wdata0[i];
                ea  = (g >= 0) ? ga : (!free ? rd_addr_m[i] : 32'h0);
                chk("ready0", i, 32'(ready0[i]), 32'(g == 0));
                chk("ready1", i, 32'(ready1[i]), 32'(g == 1));
                chk("rvalid0", i, 32'(rvalid0[i]), 32'(rv_due[i] == n_cyc[i] && !rv_port[i]));
                chk("rvalid1", i, 32'(rvalid1[i]), 32'(rv_due[i] == n_cyc[i] && rv_port[i]));
                chk("rdata0", i, rdata0[i], exp_rd0[i]);
                chk("rdata1", i, rdata1[i], exp_rd1[i]);
                chk("mem_wren", i, 32'(mem_wren[i]), 32'(g >= 0 && gwe));
                chk("mem_addr", i, mem_addr[i], ea);
                chk("mem_din", i, mem_din[i], (g >= 0) ? gd : 32'h0);
                chk("busy", i, 32'(busy[i]), 32'(!free));
                if (g >= 0) begin
                    last_m[i] = (g == 1);
                    if (gwe) begin
                        mmem[i][ga[7:2]] = gd;
                        $display("[TB] inst%0d cyc%0d p%0d WR addr=%h data=%h", i, n_cyc[i], g, ga, gd);
                    end else begin
                        free_at[i]   = n_cyc[i] + LAT[i] + 1;
                        rv_due[i]    = n_cyc[i] + LAT[i] + 1;
                        rv_port[i]   = (g == 1);
                        rv_data[i]   = mmem[i][ga[7:2]];
                        rd_addr_m[i] = ga;
                        $display("[TB] inst%0d cyc%0d p%0d RD addr=%h expect=%h", i, n_cyc[i], g, ga, rv_data[i]);
                    end
                end
                n_cyc[i]++;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clr(input int i);
        req0[i] = 1'b0; we0[i] = 1'b0; addr0[i] = 32'h0; wdata0[i] = 32'h0;
        req1[i] = 1'b0; we1[i] = 1'b0; addr1[i] = 32'h0; wdata1[i] = 32'h0;
    endtask

    task automatic stimulus();
        logic [3:0] pat0;
        logic [3:0] pat1;
        pat0 = 4'b0101;
        pat1 = 4'b1010;
        repeat (2) cyc();
        rst_n = 1'b1;

        // Write then read back on the latency-1 instance.
        cyc(); req0[0] = 1; we0[0] = 1; addr0[0] = 32'h10; wdata0[0] = 32'hDEADBEEF;
        sample(); chk("lit_wr_ready", 0, 32'(ready0[0]), 32'h1);
        chk("lit_wr_wren", 0, 32'(mem_wren[0]), 32'h1);
        chk("lit_wr_addr", 0, mem_addr[0], 32'h10);
        cyc(); clr(0);
        sample(); chk("lit_wren_drop", 0, 32'(mem_wren[0]), 32'h0);
        cyc(); req0[0] = 1; addr0[0] = 32'h10;
        sample(); chk("lit_rd_ready", 0, 32'(ready0[0]), 32'h1);
        cyc(); clr(0);
        sample(); chk("lit_rd_busy", 0, 32'(busy[0]), 32'h1);
        chk("lit_rd_early", 0, 32'(rvalid0[0]), 32'h0);
        cyc();
        sample(); chk("lit_rd_rvalid", 0, 32'(rvalid0[0]), 32'h1);
        chk("lit_rd_data", 0, rdata0[0], 32'hDEADBEEF);
        cyc();
        sample(); chk("lit_rd_pulse", 0, 32'(rvalid0[0]), 32'h0);
        chk("lit_rd_hold", 0, rdata0[0], 32'hDEADBEEF);

        // Continuous competing writes alternate once p1 was granted last.
        cyc(); req1[0] = 1; we1[0] = 1; addr1[0] = 32'h30; wdata1[0] = 32'h30303030;
        sample(); chk("lit_p1_wr", 0, 32'(ready1[0]), 32'h1);
        cyc();
        req0[0] = 1; we0[0] = 1; addr0[0] = 32'h20; wdata0[0] = 32'hA0A0A0A0;
        req1[0] = 1; we1[0] = 1; addr1[0] = 32'h24; wdata1[0] = 32'hB1B1B1B1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) cyc();
            sample();
            chk("lit_rr_ready0", 0, 32'(ready0[0]), 32'(pat0[k]));
            chk("lit_rr_ready1", 0, 32'(ready1[0]), 32'(pat1[k]));
        end
        cyc(); clr(0);

        // Latency-3 instance: p1 read blocks p0's write until the rvalid cycle.
        req0[1] = 1; we0[1] = 1; addr0[1] = 32'h40; wdata0[1] = 32'h1111;
        sample(); chk("lit_l3_pre", 1, 32'(ready0[1]), 32'h1);
        cyc(); addr0[1] = 32'h44; wdata0[1] = 32'h55;
        req1[1] = 1; we1[1] = 0; addr1[1] = 32'h08;
        sample(); chk("lit_l3_p1acc", 1, 32'(ready1[1]), 32'h1);
        chk("lit_l3_p0wait", 1, 32'(ready0[1]), 32'h0);
        cyc(); req1[1] = 0;
        sample(); chk("lit_l3_p0wait", 1, 32'(ready0[1]), 32'h0);
        chk("lit_l3_busy", 1, 32'(busy[1]), 32'h1);
        repeat (2) begin
            cyc(); sample(); chk("lit_l3_p0wait", 1, 32'(ready0[1]), 32'h0);
        end
        cyc();
        sample(); chk("lit_l3_rvalid1", 1, 32'(rvalid1[1]), 32'h1);
        chk("lit_l3_rdata1", 1, rdata1[1], 32'h33);
        chk("lit_l3_p0acc", 1, 32'(ready0[1]), 32'h1);
        chk("lit_l3_rvalid0", 1, 32'(rvalid0[1]), 32'h0);
        cyc(); clr(1);
        sample(); chk("lit_l3_pulse", 1, 32'(rvalid1[1]), 32'h0);

        // Back-to-back reads on the latency-1 instance.
        cyc(); req0[0] = 1; we0[0] = 0; addr0[0] = 32'h0;
        sample(); chk("lit_bb_acc0", 0, 32'(ready0[0]), 32'h1);
        cyc(); clr(0);
        sample(); chk("lit_bb_busy0", 0, 32'(busy[0]), 32'h1);
        cyc(); req0[0] = 1; addr0[0] = 32'h4;
        sample(); chk("lit_bb_rv0", 0, 32'(rvalid0[0]), 32'h1);
        chk("lit_bb_d0", 0, rdata0[0], 32'h11);
        chk("lit_bb_acc1", 0, 32'(ready0[0]), 32'h1);
        cyc(); clr(0);
        sample(); chk("lit_bb_busy1", 0, 32'(busy[0]), 32'h1);
        chk("lit_bb_gap", 0, 32'(rvalid0[0]), 32'h0);
        cyc();
        sample(); chk("lit_bb_rv1", 0, 32'(rvalid0[0]), 32'h1);
        chk("lit_bb_d1", 0, rdata0[0], 32'h22);
        chk("lit_bb_idle", 0, 32'(busy[0]), 32'h0);

        // Latency-4 instance: reset lands mid-read.
        cyc(); req0[2] = 1; we0[2] = 0; addr0[2] = 32'h4;
        sample(); chk("lit_l4_acc", 2, 32'(ready0[2]), 32'h1);
        cyc(); clr(2);
        sample(); chk("lit_l4_busy", 2, 32'(busy[2]), 32'h1);
        cyc(); sample();
        cyc(); rst_n = 1'b0;
        sample(); chk("lit_l4_rstbusy", 2, 32'(busy[2]), 32'h0);
        chk("lit_l4_rstaddr", 2, mem_addr[2], 32'h0);
        chk("lit_l0_rstdata", 0, rdata0[0], 32'h0);
        cyc(); sample();
        cyc(); rst_n = 1'b1;
        repeat (6) begin
            cyc(); sample(); chk("lit_l4_norv", 2, 32'(rvalid0[2]), 32'h0);
        end
        cyc();
        req0[2] = 1; we0[2] = 1; addr0[2] = 32'h50; wdata0[2] = 32'h77;
        req1[2] = 1; we1[2] = 1; addr1[2] = 32'h54; wdata1[2] = 32'h88;
        sample(); chk("lit_l4_tie0", 2, 32'(ready0[2]), 32'h1);
        chk("lit_l4_tie1", 2, 32'(ready1[2]), 32'h0);
        cyc(); clr(2);
        sample();
        repeat (2) cyc();
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            clr(i);
            for (int k = 0; k < 64; k++) mmem[i][k] = 32'h0;
            mmem[i][0] = 32'h11;
            mmem[i][1] = 32'h22;
            mmem[i][2] = 32'h33;
            n_cyc[i] = 0; free_at[i] = 0; rv_due[i] = -1; last_m[i] = 1'b1;
            rv_port[i] = 1'b0; rv_data[i] = 32'h0; rd_addr_m[i] = 32'h0;
            exp_rd0[i] = 32'h0; exp_rd1[i] = 32'h0;
        end
        fork
            begin
                forever begin
                    @(negedge clk);
                    compare_all();
                end
            end
            begin
                stimulus();
            end
        join_any
        disable fork;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter that shares the single data memory between the core's load/store port (port 0) and a loader/debug master (port 1).
- Uses valid/ready request handshakes and round-robin arbitration.
- Allows at most one outstanding read, with a parameterised memory read latency.
- Sits between the core/loader and the data memory block, driving its wren/addr/data_in and sampling its data_out.

Parameters:
ADDR_W, 32, address width of both ports and of the memory.
DATA_W, 32, data width.
MEM_LATENCY, 1, cycles from address presentation to valid mem_data_out. Legal range 1..4.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
p0_req  input  1  port 0 (core) request valid
p0_we  input  1  port 0 write (1) / read (0)
p0_addr  input  ADDR_W  port 0 address
p0_wdata  input  DATA_W  port 0 write data
p0_ready  output  1  port 0 request accepted this cycle
p0_rvalid  output  1  port 0 read data valid (one-cycle pulse)
p0_rdata  output  DATA_W  port 0 read data
p1_req, p1_we, p1_addr, p1_wdata, p1_ready, p1_rvalid, p1_rdata  same as port 0, for port 1 (loader)
mem_wren  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_data_in  output  DATA_W  memory write data
mem_data_out  input  DATA_W  memory read data
busy  output  1  read in flight (state RD_WAIT)

Behaviour:
- Handshake:
  - A transfer is accepted in a cycle where px_req && px_ready.
  - A requester holds req/we/addr/wdata stable until accepted.
  - px_ready is combinational and never asserts without px_req.
- FSM state IDLE:
  - Both requesting: grant the port not granted last (round-robin).
  - One requesting: grant it.
  - Granted port's ready=1 combinationally; mem_addr, mem_data_in and mem_wren (=we) are driven combinationally from the granted port.
  - Accepted write: completes in that cycle. mem_wren high exactly that cycle. No response. Stay IDLE, so back-to-back writes are possible every cycle.
  - Accepted read: latch addr and port id, load cnt=MEM_LATENCY, go to RD_WAIT.
- FSM state RD_WAIT:
  - Both ready=0 and mem_wren=0.
  - mem_addr is held at the latched read address.
  - cnt decrements each cycle.
  - In the cycle cnt==1, mem_data_out is valid: register it into the owning port's rdata and go to IDLE.
- Read response:
  - px_rvalid pulses in the first IDLE cycle after RD_WAIT, so read latency is MEM_LATENCY+1 cycles from acceptance.
  - A new request may be accepted in that same rvalid cycle.
- Rdata hold: px_rdata keeps its last value until that port's next read completes.
- Round-robin pointer: last_grant updates on every accept (read or write). Reset value is port 1, so port 0 wins the first tie.
- Idle outputs: when nothing is granted, mem_addr=0, mem_data_in=0, mem_wren=0.
- Reset values (async, reset low): state=IDLE, cnt=0, last_grant=1, both rvalid=0, both rdata=0, busy=0.
- Reset mid-read: the in-flight read is discarded and no rvalid is issued after reset release.
- Width rules: addresses and data pass through unmodified; no byte enables.
- cnt width: 3 bits.

Decomposition:
- Package dmem_arb_pkg:
  - state enum {IDLE, RD_WAIT}
  - port-id typedef (1 bit)
  - MEM_LATENCY legal-range constant, used by an elaboration-time assertion
- One natural sub-module: rr_arb2, the two-input round-robin grant logic (req[1:0], last_grant → grant[1:0]).
- Everything else stays in dmem_arbiter.

Test Plan:
- Reset, then p0 write addr 0x10 data 0xDEADBEEF: p0_ready=1 same cycle, mem_wren=1 for exactly one cycle, mem_addr=0x10; then p0 read 0x10 → p0_rvalid pulses 2 cycles after accept with p0_rdata=0xDEADBEEF (MEM_LATENCY=1).
- p0 and p1 both request writes continuously for 4 cycles: grants alternate p0, p1, p0, p1; each port's ready asserts only on its grant cycle.
- p1 read accepted with MEM_LATENCY=3 while p0 requests a write: p0_ready=0 for 4 cycles; p0 is accepted in the p1_rvalid cycle; p0_rvalid never asserts.
- Back-to-back reads from p0 at 0x0 then 0x4 (memory preloaded 0x11, 0x22): p0_rvalid at accept+2 and accept+4, rdata 0x11 then 0x22; busy high during each RD_WAIT.
- Assert reset during RD_WAIT (MEM_LATENCY=4, cnt=2): all outputs return to reset values immediately; no rvalid after release; first subsequent tie goes to p0.
